// File: rtl/instr_sequencer_pkg.sv
// Shared constants, types and field helpers for the instruction sequencer.
// Instruction layout: [15:12] opcode, [11:9] rx, [8:6] ry, [5:0] signed immediate.
package instr_sequencer_pkg;

  localparam int NREGS  = 8;
  localparam int REG_W  = $clog2(NREGS);
  localparam int IMM_W  = 6;
  localparam int DATA_W = 16;

  localparam int OP_LSB  = 12;
  localparam int RX_LSB  = 9;
  localparam int RY_LSB  = 6;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_MV   = 4'd1;
  localparam logic [3:0] OP_MVI  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_SUB  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_HALT = 4'd7;

  typedef enum logic [2:0] {
    S_F0,
    S_F1,
    S_T1,
    S_T2,
    S_T3,
    S_HALT
  } state_t;

  typedef struct packed {
    logic a_in;
    logic gin;
    logic gout;
    logic addsub;
    logic xorctrl;
    logic pcin;
    logic pc_sel;
    logic pcout;
    logic mem_rd;
    logic mem_out;
    logic instr_ctrl;
    logic ctrl_out;
    logic done;
    logic halted;
  } strobe_t;

  function automatic logic [3:0] get_op(input logic [DATA_W-1:0] ins);
    return ins[OP_LSB +: 4];
  endfunction

  function automatic logic [REG_W-1:0] get_rx(input logic [DATA_W-1:0] ins);
    return ins[RX_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] get_ry(input logic [DATA_W-1:0] ins);
    return ins[RY_LSB +: REG_W];
  endfunction

  function automatic logic [DATA_W-1:0] sext_imm(input logic [DATA_W-1:0] ins);
    logic [IMM_W-1:0] imm;
    imm = ins[IMM_LSB +: IMM_W];
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Control bundle between the sequencer and the datapath: instruction/run in, strobes out.
interface instr_sequencer_if;
  import instr_sequencer_pkg::*;

  logic              run;
  logic [DATA_W-1:0] instr;
  logic [NREGS-1:0]  rin;
  logic [NREGS-1:0]  rout;
  logic              a_in;
  logic              gin;
  logic              gout;
  logic              addsub;
  logic              xorctrl;
  logic              pcin;
  logic              pc_sel;
  logic              pcout;
  logic              mem_rd;
  logic              mem_out;
  logic              instr_ctrl;
  logic              ctrl_out;
  logic [DATA_W-1:0] out;
  logic              done;
  logic              halted;

  modport slave (
    input  run, instr,
    output rin, rout, a_in, gin, gout, addsub, xorctrl, pcin, pc_sel,
           pcout, mem_rd, mem_out, instr_ctrl, ctrl_out, out, done, halted
  );

  modport master (
    output run, instr,
    input  rin, rout, a_in, gin, gout, addsub, xorctrl, pcin, pc_sel,
           pcout, mem_rd, mem_out, instr_ctrl, ctrl_out, out, done, halted
  );

endinterface

// File: rtl/instr_sequencer_reg_sel_decoder.sv
// Register-field to one-hot strobe decoder; all zeros when disabled.
module reg_sel_decoder #(
  parameter int NREGS = 8
) (
  input  logic                     en,
  input  logic [$clog2(NREGS)-1:0] sel,
  output logic [NREGS-1:0]         onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode sequencer for the shared 16-bit bus CPU datapath.
// Strobes are combinational from state + instr and forced low while reset is held.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  instr_sequencer_if.slave bus
);

  state_t           state_q, state_d;
  strobe_t          strb;
  strobe_t          strb_live;
  logic             rin_en, rout_en;
  logic [REG_W-1:0] rin_sel, rout_sel;
  logic [3:0]       op;
  logic [REG_W-1:0] rx, ry;

  assign op = get_op(bus.instr);
  assign rx = get_rx(bus.instr);
  assign ry = get_ry(bus.instr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_F0;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    strb     = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rin_sel  = rx;
    rout_sel = rx;
    unique case (state_q)
      S_F0: begin
        if (bus.run) begin
          strb.pcout  = 1'b1;
          strb.mem_rd = 1'b1;
          state_d     = S_F1;
        end
      end
      S_F1: begin
        strb.mem_out    = 1'b1;
        strb.instr_ctrl = 1'b1;
        strb.pcin       = 1'b1;
        state_d         = S_T1;
      end
      S_T1: begin
        // Opcodes 8-15 fall into the default arm and behave as NOP.
        state_d   = S_F0;
        strb.done = 1'b1;
        case (op)
          OP_MV: begin
            rout_en  = 1'b1;
            rout_sel = ry;
            rin_en   = 1'b1;
          end
          OP_MVI: begin
            strb.ctrl_out = 1'b1;
            rin_en        = 1'b1;
          end
          OP_ADD, OP_SUB, OP_XOR: begin
            rout_en   = 1'b1;
            strb.a_in = 1'b1;
            strb.done = 1'b0;
            state_d   = S_T2;
          end
          OP_JMP: begin
            rout_en     = 1'b1;
            strb.pcin   = 1'b1;
            strb.pc_sel = 1'b1;
          end
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_T2: begin
        rout_en      = 1'b1;
        rout_sel     = ry;
        strb.gin     = 1'b1;
        strb.addsub  = (op == OP_SUB);
        strb.xorctrl = (op == OP_XOR);
        state_d      = S_T3;
      end
      S_T3: begin
        strb.gout = 1'b1;
        rin_en    = 1'b1;
        strb.done = 1'b1;
        state_d   = S_F0;
      end
      S_HALT: strb.halted = 1'b1;
      default: state_d = S_F0;
    endcase
  end

  assign strb_live = rst ? strb : '0;

  reg_sel_decoder #(.NREGS(NREGS)) u_rin_dec (
    .en     (rin_en & rst),
    .sel    (rin_sel),
    .onehot (bus.rin)
  );

  reg_sel_decoder #(.NREGS(NREGS)) u_rout_dec (
    .en     (rout_en & rst),
    .sel    (rout_sel),
    .onehot (bus.rout)
  );

  assign bus.a_in       = strb_live.a_in;
  assign bus.gin        = strb_live.gin;
  assign bus.gout       = strb_live.gout;
  assign bus.addsub     = strb_live.addsub;
  assign bus.xorctrl    = strb_live.xorctrl;
  assign bus.pcin       = strb_live.pcin;
  assign bus.pc_sel     = strb_live.pc_sel;
  assign bus.pcout      = strb_live.pcout;
  assign bus.mem_rd     = strb_live.mem_rd;
  assign bus.mem_out    = strb_live.mem_out;
  assign bus.instr_ctrl = strb_live.instr_ctrl;
  assign bus.ctrl_out   = strb_live.ctrl_out;
  assign bus.done       = strb_live.done;
  assign bus.halted     = strb_live.halted;
  assign bus.out        = strb_live.ctrl_out ? sext_imm(bus.instr) : '0;

endmodule
